// File: rtl/rc_osc_freq_meter.sv
// Enable/warm-up controller and windowed rising-edge counter for the 500 kHz RC oscillator.
// Optional limit check enabled by defining RC_OSC_MON_RANGE_EN (adds lo_lim, hi_lim, in_range).
module rc_osc_freq_meter #(
  parameter int unsigned CW     = 16,
  parameter int unsigned WIN_W  = 16,
  parameter int unsigned WARMUP = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             osc_in,
`ifdef RC_OSC_MON_RANGE_EN
  input  logic [CW-1:0]    lo_lim,
  input  logic [CW-1:0]    hi_lim,
  output logic             in_range,
`endif
  output logic             osc_ena,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int unsigned WU_W = $clog2(WARMUP + 1);
  localparam int unsigned TW   = (WIN_W > WU_W) ? WIN_W : WU_W;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_MEASURE, S_DONE} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             osc_rise;
  logic [TW-1:0]    timer;
  logic [WIN_W-1:0] win_q;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             ovf_q, ovf_nxt;

  assign osc_rise = s2 & ~s3;

  // Working counter: saturates at all-ones, a further increment flags overflow
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (state == S_MEASURE && osc_rise) begin
      if (&cnt_q) ovf_nxt = 1'b1;
      else        cnt_nxt = cnt_q + CW'(1);
    end
  end

`ifdef RC_OSC_MON_RANGE_EN
  logic [CW-1:0] lo_q, hi_q;
  logic          range_ok;
  assign range_ok = (cnt_nxt >= lo_q) && (cnt_nxt <= hi_q) && !ovf_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      osc_ena  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef RC_OSC_MON_RANGE_EN
      lo_q     <= '0;
      hi_q     <= '0;
      in_range <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_WARMUP;
            osc_ena <= 1'b1;
            busy    <= 1'b1;
            win_q   <= (win_len == '0) ? WIN_W'(1) : win_len;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            timer   <= TW'(WARMUP - 1);
`ifdef RC_OSC_MON_RANGE_EN
            lo_q    <= lo_lim;
            hi_q    <= hi_lim;
`endif
          end
        end
        S_WARMUP: begin
          if (abort) begin
            state   <= S_IDLE;
            osc_ena <= 1'b0;
            busy    <= 1'b0;
          end else if (timer == '0) begin
            state <= S_MEASURE;
            timer <= TW'(win_q - WIN_W'(1));
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_MEASURE: begin
          cnt_q <= cnt_nxt;
          ovf_q <= ovf_nxt;
          if (abort) begin
            state   <= S_IDLE;
            osc_ena <= 1'b0;
            busy    <= 1'b0;
          end else if (timer == '0) begin
            // Result includes the edge detected in the final window cycle
            state    <= S_DONE;
            osc_ena  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            count    <= cnt_nxt;
            overflow <= ovf_nxt;
`ifdef RC_OSC_MON_RANGE_EN
            in_range <= range_ok;
`endif
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_osc_freq_meter.sv
// Directed bench for rc_osc_freq_meter: 10 MHz clk, gated async oscillator model,
// nominal (CW=16) and saturating (CW=4) instances driven in parallel.
`timescale 1ns/1ps
module tb_rc_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] win_len = 16'd0;
  logic        osc_in = 1'b0;
  logic        osc_run = 1'b0;
  realtime     osc_half = 1000.0;

  logic        osc_ena, busy, done, overflow;
  logic [15:0] count;
  logic        s_osc_ena, s_busy, s_done, s_overflow;
  logic [3:0]  s_count;
`ifdef RC_OSC_MON_RANGE_EN
  logic [15:0] lo_lim = 16'd45;
  logic [15:0] hi_lim = 16'd55;
  logic [3:0]  s_lo = 4'd0;
  logic [3:0]  s_hi = 4'd15;
  logic        in_range, s_in_range;
`endif

  typedef struct {
    int   lo;
    int   hi;
    logic ovf;
    int   s_lo;
    int   s_hi;
    logic s_ovf;
    logic rng;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  always #50 clk = ~clk;

  // Oscillator model: free-running, phase unrelated to clk; held low while stopped
  initial begin
    #37;
    forever begin
      #(osc_half);
      if (osc_run) osc_in = ~osc_in;
      else         osc_in = 1'b0;
    end
  end

  rc_osc_freq_meter #(.CW(16), .WIN_W(16), .WARMUP(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len), .osc_in(osc_in),
`ifdef RC_OSC_MON_RANGE_EN
    .lo_lim(lo_lim), .hi_lim(hi_lim), .in_range(in_range),
`endif
    .osc_ena(osc_ena), .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  rc_osc_freq_meter #(.CW(4), .WIN_W(16), .WARMUP(64)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len), .osc_in(osc_in),
`ifdef RC_OSC_MON_RANGE_EN
    .lo_lim(s_lo), .hi_lim(s_hi), .in_range(s_in_range),
`endif
    .osc_ena(s_osc_ena), .busy(s_busy), .done(s_done), .count(s_count), .overflow(s_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    vectors++;
    assert (((obs >= 32'(lo)) && (obs <= 32'(hi))) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Full measurement: start sampled at cycle 0; results compared against the scoreboard at done
  task automatic run_meas(input logic [15:0] w, input logic with_abort, input int exp_done, input exp_t e);
    int   ena_cyc = 0;
    int   done_cyc = -1;
    int   s_done_cyc = -1;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    win_len = w;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        abort = 1'b0;
        chk("ena_at_cycle1", {30'd0, busy, osc_ena}, 32'd3);
      end
      if (s_done && s_done_cyc < 0) s_done_cyc = k;
      if (osc_ena) ena_cyc++;
      if (done) begin
        done_cyc = k;
        chk("ena_busy_low_at_done", {30'd0, busy, osc_ena}, 32'd0);
        break;
      end
    end
    chk("done_cycle", done_cyc, exp_done);
    chk("sat_done_cycle", s_done_cyc, exp_done);
    chk("ena_cycles", ena_cyc, exp_done - 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk_rng("count", count, x.lo, x.hi);
      chk("overflow", overflow, x.ovf);
      chk_rng("sat_count", s_count, x.s_lo, x.s_hi);
      chk("sat_overflow", s_overflow, x.s_ovf);
`ifdef RC_OSC_MON_RANGE_EN
      chk("in_range", in_range, x.rng);
`endif
    end
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    bit seen_done;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_osc_ena", osc_ena, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 32'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_sat_count", s_count, 32'd0);
`ifdef RC_OSC_MON_RANGE_EN
    chk("rst_in_range", in_range, 1'b0);
`endif
    rst = 1'b0;
    osc_run = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal 500 kHz, 1000-cycle window
    run_meas(16'd1000, 1'b0, 1065, '{lo:49, hi:51, ovf:1'b0, s_lo:15, s_hi:15, s_ovf:1'b1, rng:1'b1});

    // Zero window behaves as one cycle
    run_meas(16'd0, 1'b0, 66, '{lo:0, hi:1, ovf:1'b0, s_lo:0, s_hi:1, s_ovf:1'b0, rng:1'b0});

    // Oscillator stopped: exactly zero edges
    osc_run = 1'b0;
    repeat (30) @(negedge clk);
    run_meas(16'd200, 1'b0, 265, '{lo:0, hi:0, ovf:1'b0, s_lo:0, s_hi:0, s_ovf:1'b0, rng:1'b0});
    osc_run = 1'b1;

    // Abort at cycle 500, with an ignored start at cycle 10
    @(negedge clk);
    start = 1'b1;
    win_len = 16'd1000;
    seen_done = 1'b0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (k == 1)   start = 1'b0;
      if (k == 10)  start = 1'b1;
      if (k == 11)  start = 1'b0;
      if (k == 500) abort = 1'b1;
      if (k == 501) begin
        abort = 1'b0;
        chk("abort_ena_busy", {30'd0, busy, osc_ena}, 32'd0);
      end
    end
    chk("abort_no_done", seen_done, 1'b0);
    chk("abort_count_kept", count, 32'd0);
    chk("abort_ovf_kept", overflow, 1'b0);

    run_meas(16'd1000, 1'b0, 1065, '{lo:49, hi:51, ovf:1'b0, s_lo:15, s_hi:15, s_ovf:1'b1, rng:1'b1});

    // Reset at cycle 300 of a measurement
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 301; k++) begin
      @(negedge clk);
      if (k == 1)   start = 1'b0;
      if (k == 300) rst = 1'b1;
    end
    rst = 1'b0;
    chk("mid_rst_outputs", {27'd0, osc_ena, busy, done, overflow, s_overflow}, 32'd0);
    chk("mid_rst_count", count, 32'd0);
    chk("mid_rst_sat_count", s_count, 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_idle", busy, 1'b0);
    run_meas(16'd1000, 1'b0, 1065, '{lo:49, hi:51, ovf:1'b0, s_lo:15, s_hi:15, s_ovf:1'b1, rng:1'b1});

    // 600 kHz, with abort coincident with start in IDLE (start wins)
    osc_half = 833.333;
    repeat (30) @(negedge clk);
    run_meas(16'd1000, 1'b1, 1065, '{lo:59, hi:61, ovf:1'b0, s_lo:15, s_hi:15, s_ovf:1'b1, rng:1'b0});

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
